// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC sequencing, ROM fetch into an instruction register,
// decoder back-pressure, jump/call/return with a return-address stack, and halt.
module instruction_fetch_unit #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned INSTR_WIDTH = 16,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                   Clock,
   input  logic                   Reset_n,
   output logic [ADDR_WIDTH-1:0]  Address_Instruction_Bus,
   input  logic [INSTR_WIDTH-1:0] Instruction,
   output logic [INSTR_WIDTH-1:0] Instruction_Register,
   output logic                   Instruction_Valid,
   input  logic                   Decode_Ready,
   input  logic                   Jump_Enable,
   input  logic                   Call_Enable,
   input  logic                   Return_Enable,
   input  logic [ADDR_WIDTH-1:0]  Jump_Address,
   input  logic                   Halt,
   input  logic                   Resume,
   output logic                   Halted,
   output logic                   Stack_Error,
   output logic [ADDR_WIDTH-1:0]  Program_Counter
);

   localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      STALL  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t                 state;
   logic [ADDR_WIDTH-1:0]  pc;
   logic [SP_W-1:0]        sp;
   logic [ADDR_WIDTH-1:0]  stack_mem [STACK_DEPTH];

   logic                   active_c;
   logic                   stack_full_c;
   logic                   stack_empty_c;
   logic                   push_c;
   logic [IDX_W-1:0]       push_idx_c;
   logic [IDX_W-1:0]       top_idx_c;

   assign active_c      = (state != HALTED);
   assign stack_full_c  = (sp == SP_W'(STACK_DEPTH));
   assign stack_empty_c = (sp == '0);
   assign push_idx_c    = IDX_W'(sp);
   assign top_idx_c     = IDX_W'(sp - SP_W'(1));
   // A call only writes the stack when it wins precedence and a slot is free.
   assign push_c        = Reset_n && active_c && !Return_Enable && Call_Enable && !stack_full_c;

   assign Address_Instruction_Bus = pc;
   assign Program_Counter         = pc;

   always_ff @(posedge Clock) begin
      if (push_c) begin
         stack_mem[push_idx_c] <= pc;
      end
   end

   // Control flow and fetch sequencing.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state                <= FETCH;
         pc                   <= '0;
         sp                   <= '0;
         Instruction_Register <= '0;
         Instruction_Valid    <= 1'b0;
         Stack_Error          <= 1'b0;
         Halted               <= 1'b0;
      end else begin
         case (state)
            HALTED: begin
               if (Resume) begin
                  state  <= FETCH;
                  Halted <= 1'b0;
               end
            end
            default: begin
               if (Return_Enable) begin
                  state             <= FETCH;
                  Instruction_Valid <= 1'b0;
                  if (!stack_empty_c) begin
                     pc <= stack_mem[top_idx_c];
                     sp <= sp - SP_W'(1);
                  end else begin
                     Stack_Error <= 1'b1;
                  end
               end else if (Call_Enable) begin
                  state             <= FETCH;
                  Instruction_Valid <= 1'b0;
                  pc                <= Jump_Address;
                  if (!stack_full_c) begin
                     sp <= sp + SP_W'(1);
                  end else begin
                     Stack_Error <= 1'b1;
                  end
               end else if (Jump_Enable) begin
                  state             <= FETCH;
                  Instruction_Valid <= 1'b0;
                  pc                <= Jump_Address;
               end else if (Halt) begin
                  state             <= HALTED;
                  Halted            <= 1'b1;
                  Instruction_Valid <= 1'b0;
               end else if (!Instruction_Valid || Decode_Ready) begin
                  state                <= FETCH;
                  Instruction_Register <= Instruction;
                  Instruction_Valid    <= 1'b1;
                  pc                   <= pc + ADDR_WIDTH'(1);
               end else begin
                  state <= STALL;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: vector table driven cycle by
// cycle, expected state queued at drive time and compared after each edge.
module tb_instruction_fetch_unit;

   logic        Clock;
   logic        Reset_n;
   logic [7:0]  Address_Instruction_Bus;
   logic [15:0] Instruction;
   logic [15:0] Instruction_Register;
   logic        Instruction_Valid;
   logic        Decode_Ready;
   logic        Jump_Enable;
   logic        Call_Enable;
   logic        Return_Enable;
   logic [7:0]  Jump_Address;
   logic        Halt;
   logic        Resume;
   logic        Halted;
   logic        Stack_Error;
   logic [7:0]  Program_Counter;

   instruction_fetch_unit #(
      .ADDR_WIDTH (8),
      .INSTR_WIDTH(16),
      .STACK_DEPTH(4)
   ) dut (
      .Clock                  (Clock),
      .Reset_n                (Reset_n),
      .Address_Instruction_Bus(Address_Instruction_Bus),
      .Instruction            (Instruction),
      .Instruction_Register   (Instruction_Register),
      .Instruction_Valid      (Instruction_Valid),
      .Decode_Ready           (Decode_Ready),
      .Jump_Enable            (Jump_Enable),
      .Call_Enable            (Call_Enable),
      .Return_Enable          (Return_Enable),
      .Jump_Address           (Jump_Address),
      .Halt                   (Halt),
      .Resume                 (Resume),
      .Halted                 (Halted),
      .Stack_Error            (Stack_Error),
      .Program_Counter        (Program_Counter)
   );

   // ROM image: word i holds 0x1000 + i
   assign Instruction = 16'h1000 + {8'h00, Address_Instruction_Bus};

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef enum {
      OP_RST, OP_RUN, OP_STALL, OP_JMP, OP_CALL, OP_RET, OP_HALT, OP_RES,
      OP_JC, OP_ALL, OP_JH, OP_SH, OP_RSTCALL, OP_HJ
   } op_t;

   typedef struct {
      op_t         op;
      logic [7:0]  ja;
      logic [7:0]  pc;
      logic        v;
      logic [15:0] ir;
      logic        h;
      logic        e;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input op_t op, input logic [7:0] ja, input logic [7:0] pc,
                      input logic v, input logic [15:0] ir, input logic h, input logic e);
      vec_t t;
      t.op = op; t.ja = ja; t.pc = pc; t.v = v; t.ir = ir; t.h = h; t.e = e;
      vecs.push_back(t);
   endtask

   task automatic drive_op(input op_t op, input logic [7:0] ja);
      Reset_n = 1'b1; Decode_Ready = 1'b1; Jump_Enable = 1'b0; Call_Enable = 1'b0;
      Return_Enable = 1'b0; Halt = 1'b0; Resume = 1'b0; Jump_Address = ja;
      case (op)
         OP_RST:     Reset_n = 1'b0;
         OP_STALL:   Decode_Ready = 1'b0;
         OP_JMP:     Jump_Enable = 1'b1;
         OP_CALL:    Call_Enable = 1'b1;
         OP_RET:     Return_Enable = 1'b1;
         OP_HALT:    Halt = 1'b1;
         OP_RES:     Resume = 1'b1;
         OP_JC:      begin Jump_Enable = 1'b1; Call_Enable = 1'b1; end
         OP_ALL:     begin Jump_Enable = 1'b1; Call_Enable = 1'b1; Return_Enable = 1'b1; end
         OP_JH:      begin Jump_Enable = 1'b1; Halt = 1'b1; end
         OP_SH:      begin Decode_Ready = 1'b0; Halt = 1'b1; end
         OP_RSTCALL: begin Reset_n = 1'b0; Call_Enable = 1'b1; end
         OP_HJ:      begin Jump_Enable = 1'b1; Call_Enable = 1'b1; Return_Enable = 1'b1; Halt = 1'b1; end
         default:    ;
      endcase
   endtask

   initial begin
      vec_t x;
      logic [34:0] got;
      logic [34:0] want;
      int   cycles;
      logic found;

      drive_op(OP_RST, 8'h00);

      // straight-line fetch after reset, wrap-free
      add(OP_RST, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
      add(OP_RST, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int k = 1; k <= 8; k++)
         add(OP_RUN, 8'h00, 8'(k), 1'b1, 16'(16'h1000 + k - 1), 1'b0, 1'b0);

      // decoder back-pressure at PC=0x03
      add(OP_RST, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int k = 1; k <= 3; k++)
         add(OP_RUN, 8'h00, 8'(k), 1'b1, 16'(16'h1000 + k - 1), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++)
         add(OP_STALL, 8'h00, 8'h03, 1'b1, 16'h1002, 1'b0, 1'b0);
      add(OP_RUN, 8'h00, 8'h04, 1'b1, 16'h1003, 1'b0, 1'b0);

      // call/return round trip from PC=0x05
      add(OP_RST, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int k = 1; k <= 5; k++)
         add(OP_RUN, 8'h00, 8'(k), 1'b1, 16'(16'h1000 + k - 1), 1'b0, 1'b0);
      add(OP_CALL, 8'h40, 8'h40, 1'b0, 16'h1004, 1'b0, 1'b0);
      add(OP_RUN,  8'h00, 8'h41, 1'b1, 16'h1040, 1'b0, 1'b0);
      add(OP_RUN,  8'h00, 8'h42, 1'b1, 16'h1041, 1'b0, 1'b0);
      add(OP_RET,  8'h00, 8'h05, 1'b0, 16'h1041, 1'b0, 1'b0);
      add(OP_RUN,  8'h00, 8'h06, 1'b1, 16'h1005, 1'b0, 1'b0);

      // five nested calls overflow a 4-deep stack, then unwind LIFO and underflow
      add(OP_CALL, 8'h20, 8'h20, 1'b0, 16'h1005, 1'b0, 1'b0);
      add(OP_CALL, 8'h30, 8'h30, 1'b0, 16'h1005, 1'b0, 1'b0);
      add(OP_CALL, 8'h40, 8'h40, 1'b0, 16'h1005, 1'b0, 1'b0);
      add(OP_CALL, 8'h50, 8'h50, 1'b0, 16'h1005, 1'b0, 1'b0);
      add(OP_CALL, 8'h60, 8'h60, 1'b0, 16'h1005, 1'b0, 1'b1);
      add(OP_RET,  8'h00, 8'h40, 1'b0, 16'h1005, 1'b0, 1'b1);
      add(OP_RET,  8'h00, 8'h30, 1'b0, 16'h1005, 1'b0, 1'b1);
      add(OP_RET,  8'h00, 8'h20, 1'b0, 16'h1005, 1'b0, 1'b1);
      add(OP_RET,  8'h00, 8'h06, 1'b0, 16'h1005, 1'b0, 1'b1);
      add(OP_RET,  8'h00, 8'h06, 1'b0, 16'h1005, 1'b0, 1'b1);
      add(OP_RUN,  8'h00, 8'h07, 1'b1, 16'h1006, 1'b0, 1'b1);

      // PC wrap and control precedence
      add(OP_RST, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
      add(OP_JMP, 8'hFE, 8'hFE, 1'b0, 16'h0000, 1'b0, 1'b0);
      add(OP_RUN, 8'h00, 8'hFF, 1'b1, 16'h10FE, 1'b0, 1'b0);
      add(OP_RUN, 8'h00, 8'h00, 1'b1, 16'h10FF, 1'b0, 1'b0);
      add(OP_RUN, 8'h00, 8'h01, 1'b1, 16'h1000, 1'b0, 1'b0);
      add(OP_JC,  8'h80, 8'h80, 1'b0, 16'h1000, 1'b0, 1'b0);
      add(OP_RUN, 8'h00, 8'h81, 1'b1, 16'h1080, 1'b0, 1'b0);
      add(OP_RET, 8'h00, 8'h01, 1'b0, 16'h1080, 1'b0, 1'b0);
      add(OP_ALL, 8'h33, 8'h01, 1'b0, 16'h1080, 1'b0, 1'b1);
      add(OP_RUN, 8'h00, 8'h02, 1'b1, 16'h1001, 1'b0, 1'b1);
      add(OP_JH,  8'h44, 8'h44, 1'b0, 16'h1001, 1'b0, 1'b1);
      add(OP_RUN, 8'h00, 8'h45, 1'b1, 16'h1044, 1'b0, 1'b1);

      // a call during reset must not push
      add(OP_RSTCALL, 8'h70, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
      add(OP_RUN,     8'h00, 8'h01, 1'b1, 16'h1000, 1'b0, 1'b0);
      add(OP_RET,     8'h00, 8'h01, 1'b0, 16'h1000, 1'b0, 1'b1);

      // halt, reset while halted, resume, halt from stall
      add(OP_RST,   8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
      add(OP_JMP,   8'h10, 8'h10, 1'b0, 16'h0000, 1'b0, 1'b0);
      add(OP_HALT,  8'h00, 8'h10, 1'b0, 16'h0000, 1'b1, 1'b0);
      add(OP_HJ,    8'h55, 8'h10, 1'b0, 16'h0000, 1'b1, 1'b0);
      add(OP_RST,   8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
      add(OP_RUN,   8'h00, 8'h01, 1'b1, 16'h1000, 1'b0, 1'b0);
      add(OP_JMP,   8'h10, 8'h10, 1'b0, 16'h1000, 1'b0, 1'b0);
      add(OP_HALT,  8'h00, 8'h10, 1'b0, 16'h1000, 1'b1, 1'b0);
      add(OP_RES,   8'h00, 8'h10, 1'b0, 16'h1000, 1'b0, 1'b0);
      add(OP_RUN,   8'h00, 8'h11, 1'b1, 16'h1010, 1'b0, 1'b0);
      add(OP_STALL, 8'h00, 8'h11, 1'b1, 16'h1010, 1'b0, 1'b0);
      add(OP_SH,    8'h00, 8'h11, 1'b0, 16'h1010, 1'b1, 1'b0);
      add(OP_RES,   8'h00, 8'h11, 1'b0, 16'h1010, 1'b0, 1'b0);
      add(OP_RUN,   8'h00, 8'h12, 1'b1, 16'h1011, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         @(negedge Clock);
         drive_op(vecs[i].op, vecs[i].ja);
         exp_q.push_back(vecs[i]);
         @(posedge Clock);
         #1;
         x    = exp_q.pop_front();
         got  = {Address_Instruction_Bus, Program_Counter, Instruction_Valid,
                 Instruction_Register, Halted, Stack_Error};
         want = {x.pc, x.pc, x.v, x.ir, x.h, x.e};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL step%0d op=%s: got addr=%h pc=%h v=%b ir=%h halted=%b err=%b, need addr=%h pc=%h v=%b ir=%h halted=%b err=%b",
                     i, x.op.name(), Address_Instruction_Bus, Program_Counter, Instruction_Valid,
                     Instruction_Register, Halted, Stack_Error, x.pc, x.pc, x.v, x.ir, x.h, x.e);
         end
      end

      // first word after reset release arrives within one cycle
      @(negedge Clock);
      drive_op(OP_RST, 8'h00);
      @(negedge Clock);
      drive_op(OP_RUN, 8'h00);
      cycles = 0;
      found  = 1'b0;
      while (!found && cycles < 4) begin
         @(posedge Clock);
         #1;
         cycles++;
         if (Instruction_Valid === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || cycles != 1 || Instruction_Register !== 16'h1000) begin
         errors++;
         $display("FAIL first_fetch_latency: got found=%b cycles=%0d ir=%h, need found=1 cycles=1 ir=1000",
                  found, cycles, Instruction_Register);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
